// File: rtl/cover_toggle_sched.sv
// rtl/cover_toggle_sched.sv - round-robin drain of sticky toggle-coverage hits onto one report channel
module cover_toggle_sched #(
    parameter int NUM_SRC    = 4,
    parameter int SRC_W      = 39,
    parameter int COVER_BASE = 0,
    parameter int IDX_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic [NUM_SRC*SRC_W-1:0] hit,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [IDX_W-1:0]         out_index,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     all_covered,
    output logic                     busy
);

    localparam int TOT   = NUM_SRC * SRC_W;
    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [TOT-1:0]   pend;
    logic [TOT-1:0]   rep;
    logic [TOT-1:0]   flight;
    logic [TOT-1:0]   cap;
    logic [TOT-1:0]   cand;
    logic [TOT-1:0]   sel_mask;
    logic [TOT-1:0]   load_mask;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] next_ptr;
    logic [IDX_W-1:0] sel_index;
    logic             found;
    logic             load;
    logic             accept;

    // Same-cycle hits join the candidate set so an idle channel answers in one cycle;
    // the in-flight bit is masked so it is never pended twice.
    assign cap       = en ? (hit & ~rep & ~flight) : '0;
    assign cand      = pend | cap;
    assign accept    = out_valid && out_ready;
    assign load      = (!out_valid || out_ready) && found;
    assign load_mask = load ? sel_mask : '0;

    always_comb begin
        int               g;
        int               b;
        int               gk;
        logic [SRC_W-1:0] grp;
        found = 1'b0;
        g     = 0;
        b     = 0;
        gk    = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            gk = (int'(rr_ptr) + k) % NUM_SRC;
            if (!found && (|cand[gk*SRC_W +: SRC_W])) begin
                found = 1'b1;
                g     = gk;
            end
        end
        grp = cand[g*SRC_W +: SRC_W];
        for (int i = SRC_W - 1; i >= 0; i--) begin
            if (grp[i]) b = i;
        end
        sel_mask  = found ? (TOT'(1) << (g * SRC_W + b)) : '0;
        sel_index = IDX_W'(COVER_BASE + g * SRC_W + b);
        next_ptr  = PTR_W'((g + 1) % NUM_SRC);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend      <= '0;
            rep       <= '0;
            flight    <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            hit_count <= '0;
        end else if (clear) begin
            pend      <= '0;
            rep       <= '0;
            flight    <= '0;
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            hit_count <= '0;
        end else begin
            pend <= cand & ~load_mask;
            if (accept) begin
                rep <= rep | flight;
                if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_index <= sel_index;
                flight    <= sel_mask;
                rr_ptr    <= next_ptr;
            end else if (!out_valid || out_ready) begin
                out_valid <= 1'b0;
                flight    <= '0;
            end
        end
    end

    assign all_covered = (hit_count == CNT_W'(TOT));
    assign busy        = (|pend) || out_valid;

endmodule

// File: tb/tb_cover_toggle_sched.sv
// tb/tb_cover_toggle_sched.sv - directed self-checking bench for cover_toggle_sched
module tb_cover_toggle_sched;

    localparam int NUM_SRC = 4;
    localparam int SRC_W   = 39;
    localparam int TOT     = NUM_SRC * SRC_W;

    logic           clock = 1'b0;
    logic           reset;
    logic           en;
    logic [TOT-1:0] hit;
    logic           clear;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_index;
    logic [15:0]    hit_count;
    logic           all_covered;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int got_q[$];
    int got_t[$];

    cover_toggle_sched dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .hit        (hit),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_index  (out_index),
        .hit_count  (hit_count),
        .all_covered(all_covered),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are set at the falling edge; any handshake seen now completes at the next rising edge.
    task automatic tick();
        if (out_valid && out_ready && !clear && !reset) begin
            got_q.push_back(int'(out_index));
            got_t.push_back(cyc);
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        hit   = '0;
        tick();
        clear = 1'b0;
        got_q.delete();
        got_t.delete();
    endtask

    task automatic hit_one(input int idx);
        hit      = '0;
        hit[idx] = 1'b1;
    endtask

    initial begin
        int bad;
        reset     = 1'b1;
        en        = 1'b1;
        hit       = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 0);
        check("rst_index", out_index, 0);
        check("rst_count", 32'(hit_count), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_allcov", 32'(all_covered), 0);

        // single hit, one-cycle latency
        hit_one(3);
        tick();
        hit = '0;
        check("t1_valid", 32'(out_valid), 1);
        check("t1_index", out_index, 3);
        out_ready = 1'b1;
        tick();
        check("t1_count", 32'(hit_count), 1);
        check("t1_busy", 32'(busy), 0);
        check("t1_valid_low", 32'(out_valid), 0);

        // held hit reported once
        do_clear();
        hit_one(3);
        repeat (10) tick();
        hit = '0;
        repeat (3) tick();
        check("t2_emits", 32'(got_q.size()), 1);
        check("t2_index", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hffff_ffff, 3);
        check("t2_count", 32'(hit_count), 1);

        // round-robin order across groups
        do_clear();
        hit = '0;
        hit[5] = 1'b1; hit[39] = 1'b1; hit[85] = 1'b1; hit[1] = 1'b1;
        tick();
        hit = '0;
        repeat (8) tick();
        check("t3_emits", 32'(got_q.size()), 4);
        if (got_q.size() == 4) begin
            check("t3_idx0", 32'(got_q[0]), 1);
            check("t3_idx1", 32'(got_q[1]), 39);
            check("t3_idx2", 32'(got_q[2]), 85);
            check("t3_idx3", 32'(got_q[3]), 5);
            check("t3_span", 32'(got_t[3] - got_t[0]), 3);
        end
        check("t3_count", 32'(hit_count), 4);

        // backpressure holds index stable
        do_clear();
        out_ready = 1'b0;
        hit_one(155);
        tick();
        hit = '0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!out_valid || out_index != 155) bad++;
            tick();
        end
        check("t4_stable", 32'(bad), 0);
        check("t4_nocount", 32'(hit_count), 0);
        out_ready = 1'b1;
        repeat (2) tick();
        check("t4_count", 32'(hit_count), 1);
        check("t4_emits", 32'(got_q.size()), 1);

        // clear discards a same-cycle acceptance
        do_clear();
        out_ready = 1'b0;
        hit_one(3);
        tick();
        hit = '0;
        check("t5_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        clear     = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_valid_low", 32'(out_valid), 0);
        check("t5_count", 32'(hit_count), 0);
        hit_one(3);
        tick();
        hit = '0;
        repeat (2) tick();
        check("t5_rehit", 32'(hit_count), 1);
        check("t5_reidx", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1]) : 32'hffff_ffff, 3);

        // capture disabled
        do_clear();
        en = 1'b0;
        hit_one(7);
        repeat (2) tick();
        hit = '0;
        check("t6_en_valid", 32'(out_valid), 0);
        check("t6_en_busy", 32'(busy), 0);
        en = 1'b1;

        // full coverage sweep
        do_clear();
        for (int i = 0; i < TOT; i++) begin
            hit_one(i);
            tick();
        end
        hit = '0;
        repeat (4) tick();
        check("t7_emits", 32'(got_q.size()), TOT);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] != i) bad++;
        check("t7_order", 32'(bad), 0);
        check("t7_count", 32'(hit_count), TOT);
        check("t7_allcov", 32'(all_covered), 1);
        got_q.delete();
        hit = '1;
        repeat (3) tick();
        hit = '0;
        repeat (2) tick();
        check("t7_noemit", 32'(got_q.size()), 0);
        check("t7_idle", 32'(busy), 0);

        // asynchronous reset mid-transfer
        do_clear();
        out_ready = 1'b0;
        hit_one(40);
        tick();
        hit = '0;
        check("t8_valid", 32'(out_valid), 1);
        reset = 1'b1;
        #1;
        check("t8_async_valid", 32'(out_valid), 0);
        check("t8_async_count", 32'(hit_count), 0);
        @(negedge clock);
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        check("t8_after", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
